// File: rtl/mand_pkg.sv
// Shared types and constants for the Mandelbrot/Julia iteration engine.
package mand_pkg;

  localparam int DEF_WIDTH  = 27;
  localparam int DEF_FRAC   = 20;
  localparam int DEF_ITER_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Escape threshold |z|^2 = 4.0, expressed in the engine's fixed-point scale.
  function automatic longint ESCAPE_MAG(input int frac);
    return longint'(4) <<< frac;
  endfunction

endpackage

// File: rtl/mand_fx_mult.sv
// Signed fixed-point multiply: full 2*WIDTH product, arithmetic shift by FRAC,
// then narrowed to OUT_W bits for the caller.
module mand_fx_mult
  import mand_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int OUT_W = 2 * DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [OUT_W-1:0] p
);

  logic signed [2*WIDTH-1:0] a_x;
  logic signed [2*WIDTH-1:0] b_x;
  logic signed [2*WIDTH-1:0] full;

  assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
  assign full = a_x * b_x;
  assign p    = OUT_W'(full >>> FRAC);

endmodule

// File: rtl/mand_iter_engine.sv
// Handshaked escape-time engine for z <- z^2 + c. States: IDLE accept, MULT square,
// UPDATE test/step, DONE present result. Optional MAND_ITER_JULIA_EN adds a z0 seed.
module mand_iter_engine
  import mand_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int FRAC   = DEF_FRAC,
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  c_re,
  input  logic signed [WIDTH-1:0]  c_im,
  input  logic        [ITER_W-1:0] max_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [ITER_W-1:0] out_iter,
  output logic                     out_escaped
`ifdef MAND_ITER_JULIA_EN
  ,
  input  logic                     julia_mode,
  input  logic signed [WIDTH-1:0]  z0_re,
  input  logic signed [WIDTH-1:0]  z0_im
`endif
);

  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] ESC_LIM = SW'(ESCAPE_MAG(FRAC));

  if (WIDTH - FRAC < 5) begin : g_bad_params
    $error("mand_iter_engine: WIDTH - FRAC must be at least 5");
  end

  state_t                    state;
  logic signed [WIDTH-1:0]   c_re_q;
  logic signed [WIDTH-1:0]   c_im_q;
  logic        [ITER_W-1:0]  max_q;
  logic        [ITER_W-1:0]  n;
  logic signed [WIDTH-1:0]   z_re;
  logic signed [WIDTH-1:0]   z_im;
  logic signed [SW-1:0]      rr_q;
  logic signed [SW-1:0]      ii_q;
  logic signed [SW-1:0]      ri_q;
  logic signed [SW-1:0]      rr_p;
  logic signed [SW-1:0]      ii_p;
  logic signed [SW-1:0]      ri_p;
  logic signed [SW-1:0]      mag;
  logic signed [SW-1:0]      c_re_x;
  logic signed [SW-1:0]      c_im_x;
  logic signed [WIDTH-1:0]   seed_re;
  logic signed [WIDTH-1:0]   seed_im;

  mand_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(SW)) u_mult_rr (.a(z_re), .b(z_re), .p(rr_p));
  mand_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(SW)) u_mult_ii (.a(z_im), .b(z_im), .p(ii_p));
  mand_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_W(SW)) u_mult_ri (.a(z_re), .b(z_im), .p(ri_p));

`ifdef MAND_ITER_JULIA_EN
  assign seed_re = julia_mode ? z0_re : c_re;
  assign seed_im = julia_mode ? z0_im : c_im;
`else
  assign seed_re = c_re;
  assign seed_im = c_im;
`endif

  assign mag    = rr_q + ii_q;
  assign c_re_x = {{2{c_re_q[WIDTH-1]}}, c_re_q};
  assign c_im_x = {{2{c_im_q[WIDTH-1]}}, c_im_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      n           <= '0;
      z_re        <= '0;
      z_im        <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      max_q       <= '0;
      rr_q        <= '0;
      ii_q        <= '0;
      ri_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            c_re_q   <= c_re;
            c_im_q   <= c_im;
            max_q    <= max_iter;
            z_re     <= seed_re;
            z_im     <= seed_im;
            n        <= '0;
            in_ready <= 1'b0;
            state    <= MULT;
          end
        end
        MULT: begin
          rr_q  <= rr_p;
          ii_q  <= ii_p;
          ri_q  <= ri_p;
          state <= UPDATE;
        end
        UPDATE: begin
          // Escape takes priority so max_iter=0 still tests the seed point.
          if (mag > ESC_LIM) begin
            out_iter    <= n;
            out_escaped <= 1'b1;
            state       <= DONE;
          end else if (n == max_q) begin
            out_iter    <= max_q;
            out_escaped <= 1'b0;
            state       <= DONE;
          end else begin
            z_re  <= WIDTH'(rr_q - ii_q + c_re_x);
            z_im  <= WIDTH'((ri_q <<< 1) + c_im_x);
            n     <= n + ITER_W'(1);
            state <= MULT;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mand_iter_engine.sv
// Self-checking bench for mand_iter_engine: directed corner cases plus random
// points checked against an escape-time reference model.
module tb_mand_iter_engine;

  localparam int WIDTH  = 27;
  localparam int FRAC   = 20;
  localparam int ITER_W = 16;
  localparam longint ONE = longint'(1) <<< FRAC;
  localparam int LAT_BOUND = 3000;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [WIDTH-1:0]  c_re;
  logic signed [WIDTH-1:0]  c_im;
  logic        [ITER_W-1:0] max_iter;
  logic                     out_valid;
  logic                     out_ready;
  logic        [ITER_W-1:0] out_iter;
  logic                     out_escaped;
  logic                     julia_mode;
  logic signed [WIDTH-1:0]  z0_re;
  logic signed [WIDTH-1:0]  z0_im;

  int checks   = 0;
  int failures = 0;

  mand_iter_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .c_re        (c_re),
    .c_im        (c_im),
    .max_iter    (max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped)
`ifdef MAND_ITER_JULIA_EN
    ,
    .julia_mode  (julia_mode),
    .z0_re       (z0_re),
    .z0_im       (z0_im)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic longint wrapw(input longint x);
    logic [WIDTH-1:0] t;
    t = x[WIDTH-1:0];
    return longint'($signed(t));
  endfunction

  // Escape-time rule: test |z|^2 > 4 first, then the limit, else step z.
  function automatic void model(input longint cr, input longint ci, input longint zr0,
                                input longint zi0, input int mi, output int it, output bit esc);
    longint zr, zi, rr, ii, ri;
    zr  = zr0;
    zi  = zi0;
    it  = mi;
    esc = 1'b0;
    for (int k = 0; k <= mi; k++) begin
      rr = (zr * zr) >>> FRAC;
      ii = (zi * zi) >>> FRAC;
      ri = (zr * zi) >>> FRAC;
      if (rr + ii > (longint'(4) <<< FRAC)) begin
        it  = k;
        esc = 1'b1;
        return;
      end
      if (k == mi) begin
        it = mi;
        return;
      end
      zr = wrapw(rr - ii + cr);
      zi = wrapw(2 * ri + ci);
    end
  endfunction

  // Issue one request and wait for the result; leaves it held with out_ready=0.
  task automatic do_req(input string tag, input longint cr, input longint ci, input int mi,
                        input bit jm, input longint zr, input longint zi,
                        input int exp_iter, input bit exp_esc);
    int lat;
    @(negedge clock);
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    c_re       = WIDTH'(cr);
    c_im       = WIDTH'(ci);
    max_iter   = ITER_W'(mi);
    julia_mode = jm;
    z0_re      = WIDTH'(zr);
    z0_im      = WIDTH'(zi);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    c_re     = WIDTH'($urandom);
    c_im     = WIDTH'($urandom);
    max_iter = ITER_W'($urandom);
    z0_re    = WIDTH'($urandom);
    check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < LAT_BOUND) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(2 * exp_iter + 3));
    check({tag, "_iter"}, 64'(out_iter), 64'(exp_iter));
    check({tag, "_escaped"}, 64'(out_escaped), 64'(exp_esc));
  endtask

  task automatic release_out(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int    it;
    bit    esc;
    bit    jm;
    longint cr, ci, zr, zi;
    int    mi;
    logic [ITER_W-1:0] held_iter;
    logic              held_esc;

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    c_re       = '0;
    c_im       = '0;
    max_iter   = '0;
    julia_mode = 1'b0;
    z0_re      = '0;
    z0_im      = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_iter", 64'(out_iter), 64'd0);
    check("rst_out_escaped", 64'(out_escaped), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    do_req("origin", 0, 0, 100, 1'b0, 0, 0, 100, 1'b0);
    release_out("origin");

    do_req("c3", 3 * ONE, 0, 100, 1'b0, 0, 0, 0, 1'b1);
    release_out("c3");

    do_req("c1", ONE, 0, 100, 1'b0, 0, 0, 2, 1'b1);
    release_out("c1");

    do_req("cm2", -2 * ONE, 0, 50, 1'b0, 0, 0, 50, 1'b0);
    release_out("cm2");

    do_req("max0_esc", 3 * ONE, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    release_out("max0_esc");

    do_req("max0_bnd", ONE / 2, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    release_out("max0_bnd");

    // Backpressure: result held stable for 10 cycles with out_ready low.
    do_req("bp", ONE, 0, 100, 1'b0, 0, 0, 2, 1'b1);
    held_iter = out_iter;
    held_esc  = out_escaped;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_iter_hold", 64'(out_iter), 64'd2);
      check("bp_esc_hold", 64'(out_escaped), 64'(held_esc));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    check("bp_iter_unchanged", 64'(out_iter), 64'(held_iter));
    release_out("bp");

    // Reset while the engine is in UPDATE (one edge after MULT).
    @(negedge clock);
    in_valid = 1'b1;
    c_re     = '0;
    c_im     = '0;
    max_iter = ITER_W'(100);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    do_req("post_rst", 3 * ONE, 0, 10, 1'b0, 0, 0, 0, 1'b1);
    release_out("post_rst");

`ifdef MAND_ITER_JULIA_EN
    do_req("julia_on", ONE, 0, 100, 1'b1, 0, 0, 3, 1'b1);
    release_out("julia_on");
    do_req("julia_off", ONE, 0, 100, 1'b0, 0, 0, 2, 1'b1);
    release_out("julia_off");
`endif

    for (int r = 0; r < 14; r++) begin
      cr = longint'($urandom_range(0, 3 * (1 << FRAC))) - 2 * ONE;
      ci = longint'($urandom_range(0, 3 * (1 << FRAC))) - (3 * ONE) / 2;
      mi = int'($urandom_range(0, 40));
      zr = longint'($urandom_range(0, 3 * (1 << FRAC))) - (3 * ONE) / 2;
      zi = longint'($urandom_range(0, 3 * (1 << FRAC))) - (3 * ONE) / 2;
`ifdef MAND_ITER_JULIA_EN
      jm = 1'($urandom_range(0, 1));
`else
      jm = 1'b0;
`endif
      if (jm) model(cr, ci, zr, zi, mi, it, esc);
      else    model(cr, ci, cr, ci, mi, it, esc);
      do_req($sformatf("rand%0d", r), cr, ci, mi, jm, zr, zi, it, esc);
      release_out($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
